// File: rtl/timer_avmm_pkg.sv
// Shared register map, control bit positions and FSM state encoding for the timer AVMM master.
// The snapshot states exist only when TIMER_AVMM_MASTER_SNAP_EN is defined.
package timer_avmm_pkg;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
    localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

    localparam int unsigned CTRL_ITO   = 0;
    localparam int unsigned CTRL_CONT  = 1;
    localparam int unsigned CTRL_START = 2;
    localparam int unsigned CTRL_STOP  = 3;

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTRL,
        RUN,
        CLR,
        WR_STOP
`ifdef TIMER_AVMM_MASTER_SNAP_EN
        ,
        SNAP_W,
        SNAP_RL,
        SNAP_RH,
        SNAP_CAP
`endif
    } state_t;

endpackage

// File: rtl/timer_avmm_master_if.sv
// Avalon-MM bus (3-bit address, 16-bit data, read latency 1) plus the slave's level interrupt.
interface timer_avmm_master_if;

    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata;
    logic        irq;

    modport master (
        output avm_address, avm_chipselect, avm_write_n, avm_writedata,
        input  avm_readdata, irq
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
        output avm_readdata, irq
    );

endinterface

// File: rtl/timer_avmm_master.sv
// Avalon-MM master that programs, services and optionally snapshots a timer slave.
// Macro TIMER_AVMM_MASTER_SNAP_EN enables the snapshot sequence (snap_req/snap_value/snap_valid).
module timer_avmm_master
    import timer_avmm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        snap_req,
    input  logic [31:0] cfg_period,
    input  logic        cfg_continuous,
    output logic        busy,
    output logic        tick,
    output logic [15:0] tick_count,
    output logic [31:0] snap_value,
    output logic        snap_valid,
    timer_avmm_master_if.master avm
);

    state_t      state, next_state;
    logic [31:0] period_q;
    logic        cont_q;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = WR_PL;
            WR_PL:   next_state = WR_PH;
            WR_PH:   next_state = WR_CTRL;
            WR_CTRL: next_state = RUN;
            RUN: begin
                if (avm.irq)   next_state = CLR;
                else if (stop) next_state = WR_STOP;
`ifdef TIMER_AVMM_MASTER_SNAP_EN
                else if (snap_req) next_state = SNAP_W;
`endif
            end
            CLR:     next_state = cont_q ? RUN : IDLE;
            WR_STOP: next_state = IDLE;
`ifdef TIMER_AVMM_MASTER_SNAP_EN
            SNAP_W:   next_state = SNAP_RL;
            SNAP_RL:  next_state = SNAP_RH;
            SNAP_RH:  next_state = SNAP_CAP;
            SNAP_CAP: next_state = RUN;
`endif
            default: next_state = IDLE;
        endcase
    end

    // Bus command is decoded from the registered state, so each access spans exactly that state's cycle.
    always_comb begin
        avm.avm_chipselect = 1'b0;
        avm.avm_write_n    = 1'b1;
        avm.avm_address    = '0;
        avm.avm_writedata  = '0;
        case (state)
            WR_PL: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_write_n    = 1'b0;
                avm.avm_address    = ADDR_PERIOD_L;
                avm.avm_writedata  = period_q[15:0];
            end
            WR_PH: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_write_n    = 1'b0;
                avm.avm_address    = ADDR_PERIOD_H;
                avm.avm_writedata  = period_q[31:16];
            end
            WR_CTRL: begin
                avm.avm_chipselect            = 1'b1;
                avm.avm_write_n               = 1'b0;
                avm.avm_address               = ADDR_CONTROL;
                avm.avm_writedata[CTRL_ITO]   = 1'b1;
                avm.avm_writedata[CTRL_START] = 1'b1;
                avm.avm_writedata[CTRL_CONT]  = cont_q;
            end
            CLR: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_write_n    = 1'b0;
                avm.avm_address    = ADDR_STATUS;
            end
            WR_STOP: begin
                avm.avm_chipselect           = 1'b1;
                avm.avm_write_n              = 1'b0;
                avm.avm_address              = ADDR_CONTROL;
                avm.avm_writedata[CTRL_STOP] = 1'b1;
            end
`ifdef TIMER_AVMM_MASTER_SNAP_EN
            SNAP_W: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_write_n    = 1'b0;
                avm.avm_address    = ADDR_SNAP_L;
            end
            SNAP_RL: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_address    = ADDR_SNAP_L;
            end
            SNAP_RH: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_address    = ADDR_SNAP_H;
            end
`endif
            default: ;
        endcase
    end

    assign busy = (state != IDLE);
    assign tick = (state == CLR);

    always_ff @(posedge clk) begin
        if (reset) begin
            period_q   <= '0;
            cont_q     <= 1'b0;
            tick_count <= '0;
        end else begin
            if (state == IDLE && start) begin
                period_q   <= cfg_period;
                cont_q     <= cfg_continuous;
                tick_count <= '0;
            end
            if (state == CLR) tick_count <= tick_count + 16'd1;
        end
    end

`ifdef TIMER_AVMM_MASTER_SNAP_EN
    // Read latency 1: data for the SNAP_RL read arrives in SNAP_RH, for SNAP_RH in SNAP_CAP.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_value <= '0;
            snap_valid <= 1'b0;
        end else begin
            snap_valid <= 1'b0;
            if (state == SNAP_RH) snap_value[15:0] <= avm.avm_readdata;
            if (state == SNAP_CAP) begin
                snap_value[31:16] <= avm.avm_readdata;
                snap_valid        <= 1'b1;
            end
        end
    end
`else
    logic unused_snap;
    assign unused_snap = ^{snap_req, avm.avm_readdata};
    assign snap_value  = '0;
    assign snap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_timer_avmm_master.sv
// Directed self-checking bench for timer_avmm_master: table-driven programming vectors plus
// hand-written tick, stop, snapshot, wrap and mid-sequence reset sequences.
module tb_timer_avmm_master;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic        snap_req;
    logic [31:0] cfg_period;
    logic        cfg_continuous;
    logic        busy;
    logic        tick;
    logic [15:0] tick_count;
    logic [31:0] snap_value;
    logic        snap_valid;

    int unsigned total;
    int unsigned bad;

    timer_avmm_master_if bus ();

    timer_avmm_master dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .snap_req       (snap_req),
        .cfg_period     (cfg_period),
        .cfg_continuous (cfg_continuous),
        .busy           (busy),
        .tick           (tick),
        .tick_count     (tick_count),
        .snap_value     (snap_value),
        .snap_valid     (snap_valid),
        .avm            (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave read model: data for a read seen in one cycle is presented for the next cycle's edge.
    logic [15:0] rd_pending;
    initial begin
        bus.avm_readdata = '0;
        rd_pending       = '0;
        forever begin
            @(negedge clk);
            bus.avm_readdata = rd_pending;
            rd_pending = '0;
            if (bus.avm_chipselect && bus.avm_write_n) begin
                if (bus.avm_address == 3'd4)      rd_pending = 16'h1234;
                else if (bus.avm_address == 3'd5) rd_pending = 16'hABCD;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] bus_word();
        return {11'd0, bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata};
    endfunction

    function automatic logic [31:0] wr(input logic [2:0] a, input logic [15:0] d);
        return {11'd0, 1'b1, 1'b0, a, d};
    endfunction

    function automatic logic [31:0] rd(input logic [2:0] a);
        return {11'd0, 1'b1, 1'b1, a, 16'h0000};
    endfunction

    localparam logic [31:0] BUS_IDLE = {11'd0, 1'b0, 1'b1, 3'd0, 16'h0000};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic prog_timer(input logic [31:0] p, input logic c,
                              input logic [15:0] pl, input logic [15:0] ph, input logic [15:0] ctrl);
        cfg_period     = p;
        cfg_continuous = c;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("wr_pl", bus_word(), wr(3'd2, pl));
        chk("busy_pl", 32'(busy), 32'd1);
        @(negedge clk);
        chk("wr_ph", bus_word(), wr(3'd3, ph));
        @(negedge clk);
        chk("wr_ctrl", bus_word(), wr(3'd1, ctrl));
        @(negedge clk);
        chk("run_bus_idle", bus_word(), BUS_IDLE);
        chk("busy_run", 32'(busy), 32'd1);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("wr_stop", bus_word(), wr(3'd1, 16'h0008));
        @(negedge clk);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_bus_idle", bus_word(), BUS_IDLE);
    endtask

    task automatic do_tick(input logic exp_busy);
        bus.irq = 1'b1;
        @(negedge clk);
        chk("clr_write", bus_word(), wr(3'd0, 16'h0000));
        chk("clr_tick", 32'(tick), 32'd1);
        bus.irq = 1'b0;
        @(negedge clk);
        chk("tick_low", 32'(tick), 32'd0);
        chk("tick_busy", 32'(busy), 32'(exp_busy));
    endtask

    typedef struct {
        logic [31:0] period;
        logic        cont;
        logic [15:0] pl;
        logic [15:0] ph;
        logic [15:0] ctrl;
    } vec_t;

    vec_t tbl[4];
    int   vld_cnt;
    int   act_cnt;

    initial begin
        tbl[0] = '{32'h0001869F, 1'b1, 16'h869F, 16'h0001, 16'h0007};
        tbl[1] = '{32'h00000000, 1'b0, 16'h0000, 16'h0000, 16'h0005};
        tbl[2] = '{32'hFFFFFFFF, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0007};
        tbl[3] = '{32'hDEAD0001, 1'b0, 16'h0001, 16'hDEAD, 16'h0005};

        total = 0;
        bad = 0;
        reset = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        snap_req = 1'b0;
        cfg_period = '0;
        cfg_continuous = 1'b0;
        bus.irq = 1'b0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_tick_count", 32'(tick_count), 32'd0);
        chk("rst_snap_value", snap_value, 32'd0);
        chk("rst_snap_valid", 32'(snap_valid), 32'd0);
        chk("rst_bus", bus_word(), BUS_IDLE);

        // stop in IDLE must be ignored
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("idle_stop_bus", bus_word(), BUS_IDLE);
        chk("idle_stop_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 4; i++) begin
            prog_timer(tbl[i].period, tbl[i].cont, tbl[i].pl, tbl[i].ph, tbl[i].ctrl);
            do_stop();
        end

        // continuous mode, start ignored in RUN, three serviced timeouts
        prog_timer(32'h0001869F, 1'b1, 16'h869F, 16'h0001, 16'h0007);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("run_start_ignored", bus_word(), BUS_IDLE);
        for (int i = 0; i < 3; i++) do_tick(1'b1);
        chk("tick_count_3", 32'(tick_count), 32'd3);

        // irq and stop together: irq wins, stop is dropped
        bus.irq = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("prio_clr", bus_word(), wr(3'd0, 16'h0000));
        chk("prio_tick", 32'(tick), 32'd1);
        bus.irq = 1'b0;
        @(negedge clk);
        chk("prio_run_bus", bus_word(), BUS_IDLE);
        chk("prio_busy", 32'(busy), 32'd1);
        chk("prio_tick_count", 32'(tick_count), 32'd4);
        do_stop();

        // one-shot mode returns to IDLE after one timeout
        prog_timer(32'h00000010, 1'b0, 16'h0010, 16'h0000, 16'h0005);
        chk("oneshot_cnt_clear", 32'(tick_count), 32'd0);
        do_tick(1'b0);
        chk("oneshot_count", 32'(tick_count), 32'd1);
        chk("oneshot_bus", bus_word(), BUS_IDLE);

        // snapshot sequence
        prog_timer(32'h00001000, 1'b1, 16'h1000, 16'h0000, 16'h0007);
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
`ifdef TIMER_AVMM_MASTER_SNAP_EN
        chk("snap_w", bus_word(), wr(3'd4, 16'h0000));
        bus.irq = 1'b1;
        vld_cnt = 0;
        @(negedge clk);
        chk("snap_rl", bus_word(), rd(3'd4));
        if (snap_valid) vld_cnt++;
        @(negedge clk);
        chk("snap_rh", bus_word(), rd(3'd5));
        if (snap_valid) vld_cnt++;
        @(negedge clk);
        chk("snap_cap_bus", bus_word(), BUS_IDLE);
        if (snap_valid) vld_cnt++;
        @(negedge clk);
        chk("snap_value", snap_value, 32'hABCD1234);
        if (snap_valid) vld_cnt++;
        chk("snap_ret_run", bus_word(), BUS_IDLE);
        @(negedge clk);
        if (snap_valid) vld_cnt++;
        chk("snap_held_irq_clr", bus_word(), wr(3'd0, 16'h0000));
        bus.irq = 1'b0;
        chk("snap_valid_pulses", 32'(vld_cnt), 32'd1);
        @(negedge clk);
        chk("snap_after_busy", 32'(busy), 32'd1);
`else
        act_cnt = 0;
        vld_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.avm_chipselect) act_cnt++;
            if (snap_valid) vld_cnt++;
            @(negedge clk);
        end
        chk("nosnap_bus", 32'(act_cnt), 32'd0);
        chk("nosnap_valid", 32'(vld_cnt), 32'd0);
        chk("nosnap_value", snap_value, 32'd0);
`endif

        // tick_count wrap
        force dut.tick_count = 16'hFFFF;
        #1;
        release dut.tick_count;
        @(negedge clk);
        chk("wrap_preset", 32'(tick_count), 32'h0000FFFF);
        do_tick(1'b1);
        chk("wrap_count", 32'(tick_count), 32'd0);
        do_stop();

        // reset during WR_PH aborts the sequence
        cfg_period = 32'h00050006;
        cfg_continuous = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_in_ph", bus_word(), wr(3'd3, 16'h0005));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_bus", bus_word(), BUS_IDLE);
        act_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.avm_chipselect) act_cnt++;
        end
        chk("abort_no_ctrl", 32'(act_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_avmm_master.md
TIMER_AVMM_MASTER -- requirements
Module: timer_avmm_master

Interface
REQ-001 SHALL have no parameters; the Avalon-MM master is fixed at 3-bit address and 16-bit data.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 start  in  1  one-cycle pulse; programs and starts the timer (sampled in IDLE only).
REQ-006 stop  in  1  one-cycle pulse; stops a running timer.
REQ-007 snap_req  in  1  one-cycle pulse; requests a 32-bit counter snapshot.
REQ-008 cfg_period  in  32  period value, latched on start.
REQ-009 cfg_continuous  in  1  continuous mode, latched on start.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 tick  out  1  one-cycle pulse per serviced timeout.
REQ-012 tick_count  out  16  serviced-timeout count.
REQ-013 snap_value  out  32  last snapshot; snap_valid  out  1  one-cycle pulse when snap_value updates.
REQ-014 avm_address  out  3 / avm_chipselect  out  1 / avm_write_n  out  1 / avm_writedata  out  16: master command.
REQ-015 avm_readdata  in  16  slave data; fixed read latency 1; no waitrequest.
REQ-016 irq  in  1  level interrupt from the timer slave.

Function
REQ-017 Register map: 0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h; control bits: ITO=0, CONT=1, START=2, STOP=3.
REQ-018 Every bus access SHALL last exactly one cycle, with chipselect=1; writes use write_n=0 and reads use write_n=1.
REQ-019 When idle, the bus SHALL drive chipselect=0, write_n=1, address=0, writedata=0.
REQ-020 States: IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR, WR_STOP, SNAP_W, SNAP_RL, SNAP_RH, SNAP_CAP.
REQ-021 IDLE + start: latch cfg, clear tick_count, go to WR_PL.
  - start asserted in any other state SHALL be ignored.
REQ-022 Programming sequence: WR_PL writes addr 2 with period[15:0], then WR_PH writes addr 3 with period[31:16], then WR_CTRL writes addr 1 with 0x0005 | (cont<<1), then RUN.
  - The first write is on the bus in the cycle after start; RUN is entered 4 cycles after start.
REQ-023 RUN SHALL apply priority irq > stop > snap_req.
  - Unselected stop and snap_req pulses SHALL be dropped.
  - stop and snap_req SHALL be ignored outside RUN.
REQ-024 RUN + irq -> CLR.
  - CLR writes addr 0 with 0x0000 and pulses tick in the same cycle.
  - tick_count increments modulo 2^16 (0xFFFF -> 0x0000).
  - Next state: RUN if cont=1, else IDLE.
REQ-025 RUN + stop -> WR_STOP; WR_STOP writes addr 1 with 0x0008, then IDLE.
REQ-026 RUN + snap_req: snapshot sequence SNAP_W -> SNAP_RL -> SNAP_RH -> SNAP_CAP -> RUN.
  - SNAP_W writes addr 4 with 0.
  - SNAP_RL reads addr 4.
  - SNAP_RH reads addr 5 and captures readdata into snap_value[15:0].
  - SNAP_CAP captures readdata into snap_value[31:16] and pulses snap_valid.
REQ-027 An irq during the snapshot sequence SHALL be held by the slave and serviced on return to RUN; no timeout is lost.
REQ-028 cfg_period=0 SHALL be written unchanged; no special-casing.

Reset
REQ-029 Reset SHALL force IDLE and the idle bus values.
  - tick=0, snap_valid=0, tick_count=0, snap_value=0, busy=0, latched cfg=0.
REQ-030 Reset mid-sequence SHALL abort the sequence; no further bus cycle occurs in the cycle after reset deasserts.

Configuration
REQ-031 Macro TIMER_AVMM_MASTER_SNAP_EN.
  - Defined: snapshot states and logic are present.
  - Undefined: snap_req is ignored, snap_value is tied 0, snap_valid is tied 0, and the SNAP_* states are absent; ports are unchanged.

Structure
REQ-032 Package timer_avmm_pkg SHALL hold:
  - register address constants;
  - control bit positions;
  - the state enum typedef.
REQ-033 Single module with no sub-module; one FSM plus output registers.

Verification
REQ-034 reset, start with period=0x0001869F, cont=1 -> writes (2,0x869F), (3,0x0001), (1,0x0007) on cycles 1-3; busy=1.
REQ-035 RUN, irq held high until the status write -> one write (0,0x0000), tick pulse, tick_count 0->1, FSM back to RUN; repeat 3x -> tick_count=3.
REQ-036 cont=0, one irq -> control write 0x0005, one CLR, then IDLE; busy=0.
REQ-037 RUN, snap_req, slave model returning 0x1234 then 0xABCD -> write addr 4, reads addr 4/5, snap_value=0xABCD1234, one snap_valid pulse; with macro undefined -> no bus activity, snap_valid stays 0.
REQ-038 irq and stop in the same RUN cycle -> CLR first, then RUN; a subsequent stop -> write (1,0x0008), IDLE. tick_count preset to 0xFFFF plus one irq -> 0x0000.
REQ-039 reset asserted during WR_PH -> IDLE next cycle, bus idle, no WR_CTRL write issued.
